decoder_select_sequencer: RTL and testbench
===========================================

Name: decoder_select_sequencer

Overview:
Sequential stage directly upstream of the 3-to-8 decoder. Generates the 3-bit select code {a,b,c} (a = MSB) that drives the decoder, so its one-hot output walks through y[0]..y[7] under control.
Each code is held for a programmable dwell time. Supports one-shot sweeps and continuous scanning, up or down, with pause, stop and parallel load.

Parameters:
DWELL, 4, clock cycles each code is held while running; legal range 1..2^CNT_W.
CNT_W, 8, width of the internal dwell counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  begin a run (sampled in IDLE or DONE).
stop  input  1  abort to IDLE from any state; code is held.
pause  input  1  level; freezes the sequencer while high.
dir  input  1  0 = count up, 1 = count down; sampled at each step.
mode_cont  input  1  0 = one-shot to terminal code, 1 = continuous wrap; sampled at each step.
load  input  1  parallel load of load_val (IDLE or DONE only).
load_val  input  3  value loaded into {a,b,c}.
a  output  1  select bit 2 (MSB) to the decoder.
b  output  1  select bit 1 to the decoder.
c  output  1  select bit 0 to the decoder.
busy  output  1  high in RUN or PAUSED.
done  output  1  high in DONE.
wrap  output  1  one-cycle pulse after a wrap in continuous mode.

Behaviour:
- All outputs are registered.
- On reset, asynchronously:
  - state = IDLE
  - {a,b,c} = 000
  - dwell counter = 0
  - busy = done = wrap = 0
- States are IDLE, RUN, PAUSED and DONE.
- Priority on each edge: rst > stop > load > start > pause > dwell counting.
- IDLE:
  - load: code <= load_val.
  - start: state <= RUN, counter <= 0. Counting begins from the current code.
  - load and start together: code <= load_val and state <= RUN.
- RUN, on each edge:
  - If pause is high: state <= PAUSED; the counter and code do not change.
  - Else if counter == DWELL-1: counter <= 0 and a step occurs.
  - Else: counter <= counter + 1.
- Step timing: if start is sampled at edge E, the code changes at edges E+DWELL, E+2*DWELL, and so on.
- Terminal code is 7 when dir = 0 and 0 when dir = 1.
- Step with mode_cont = 0:
  - At the terminal code: state <= DONE and the code is held.
  - Otherwise: code +/- 1.
- Step with mode_cont = 1:
  - Code +/- 1 modulo 8.
  - On 7->0 (up) or 0->7 (down), wrap = 1 for the cycle following that edge, then returns to 0.
- PAUSED:
  - The counter and code are frozen.
  - When pause is low at an edge: state <= RUN. Counting resumes from the frozen counter value.
- DONE:
  - done is held at 1.
  - start: code is reset to the sweep origin (000 if dir = 0, 111 if dir = 1), counter <= 0, state <= RUN.
  - load: code <= load_val, state <= IDLE.
- stop in any state: state <= IDLE. The code is held; counter, done and wrap are cleared. stop wins over a simultaneous start.
- load is ignored in RUN and PAUSED.
- DWELL = 1: the code steps on every RUN edge.
- Reset asserted mid-run: returns everything to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset, then release; with DWELL=4, dir=0, mode_cont=0, pulse start at edge E -> code steps 0,1,...,7 at E+4..E+28; done=1 and busy=0 at E+32; decoder y steps 01,02,04,...,80.
- DWELL=4, load_val=101 with load and start in the same cycle, dir=1, mode_cont=1 -> code sequence 5,4,3,2,1,0,7. wrap is high for exactly one cycle after the 0->7 edge; busy stays 1.
- RUN with counter=2, then hold pause high for 5 cycles -> code and counter are frozen and busy=1. After pause falls, the next step occurs DWELL-2 RUN edges after resume.
- In RUN at code 3, assert stop and start together -> state IDLE, code stays 3, busy=0, done=0. A later start alone resumes from 3.
- In DONE at code 7, pulse start with dir=1 -> code is reloaded to 7 and sweeps down to 0, then DONE. In DONE, load_val=010 with load -> IDLE with code 2.
- Assert rst asynchronously mid-run at code 6, between clock edges -> {a,b,c}=000 and busy=done=wrap=0 before the next edge. DWELL=1 build: code steps on every edge.

Source files
------------

// File: rtl/decoder_select_sequencer.sv
// Select-code sequencer feeding a 3-to-8 decoder: walks {a,b,c} up or down,
// holding each code for DWELL cycles, in one-shot or continuous mode.
module decoder_select_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       dir,
  input  logic       mode_cont,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DWELL - 1);

  state_t           r_state, w_nextState;
  logic [2:0]       r_code, w_nextCode;
  logic [CNT_W-1:0] r_cnt, w_nextCnt;
  logic             r_busy, r_done, r_wrap;
  logic             w_nextBusy, w_nextDone, w_nextWrap;
  logic             w_atLast, w_atTerminal;
  logic [2:0]       w_terminal, w_stepCode, w_origin;

  assign w_atLast     = (r_cnt == LastCnt);
  assign w_terminal   = dir ? 3'd0 : 3'd7;
  assign w_origin     = dir ? 3'd7 : 3'd0;
  assign w_atTerminal = (r_code == w_terminal);
  assign w_stepCode   = dir ? (r_code - 3'd1) : (r_code + 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_code  <= 3'd0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_code  <= w_nextCode;
      r_cnt   <= w_nextCnt;
      r_busy  <= w_nextBusy;
      r_done  <= w_nextDone;
      r_wrap  <= w_nextWrap;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (stop) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_nextState = RUN;
        RUN: begin
          if (pause)
            w_nextState = PAUSED;
          else if (w_atLast && !mode_cont && w_atTerminal)
            w_nextState = DONE;
        end
        PAUSED:  if (!pause) w_nextState = RUN;
        DONE: begin
          if (load)
            w_nextState = IDLE;
          else if (start)
            w_nextState = RUN;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Code/counter datapath; a one-shot step at the terminal code holds the code.
  always_comb begin
    w_nextCode = r_code;
    w_nextCnt  = r_cnt;
    w_nextWrap = 1'b0;
    if (stop) begin
      w_nextCnt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load)  w_nextCode = load_val;
          if (start) w_nextCnt  = '0;
        end
        RUN: begin
          if (!pause) begin
            if (w_atLast) begin
              w_nextCnt = '0;
              if (mode_cont) begin
                w_nextCode = w_stepCode;
                w_nextWrap = w_atTerminal;
              end else if (!w_atTerminal) begin
                w_nextCode = w_stepCode;
              end
            end else begin
              w_nextCnt = r_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (load) begin
            w_nextCode = load_val;
          end else if (start) begin
            w_nextCode = w_origin;
            w_nextCnt  = '0;
          end
        end
        default: ;
      endcase
    end
    w_nextBusy = (w_nextState == RUN) || (w_nextState == PAUSED);
    w_nextDone = (w_nextState == DONE);
  end

  assign {a, b, c} = r_code;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Scoreboard bench for decoder_select_sequencer: DWELL=4 and DWELL=1 instances
// share stimulus and are each compared against a behavioural model.
module tb_decoder_select_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, dir, modeCont, load;
  logic [2:0] loadVal;
  logic       a4, b4, c4, busy4, done4, wrap4;
  logic       a1, b1, c1, busy1, done1, wrap1;

  always #5 clk = ~clk;

  decoder_select_sequencer #(.DWELL(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .dir(dir), .mode_cont(modeCont), .load(load), .load_val(loadVal),
    .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .wrap(wrap4)
  );

  decoder_select_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .dir(dir), .mode_cont(modeCont), .load(load), .load_val(loadVal),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .wrap(wrap1)
  );

  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} PhaseT;
  typedef struct {PhaseT ph; int code; int since; bit wrap;} ModelT;
  typedef struct {bit rst, start, stop, pause, dir, cont, load; int lv;} StimT;
  typedef struct {int code; bit busy, done, wrap;} ExpT;

  ModelT m4, m1;
  ExpT   q4[$], q1[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  function automatic ModelT resetModel();
    ModelT m;
    m.ph = M_IDLE; m.code = 0; m.since = 0; m.wrap = 0;
    return m;
  endfunction

  // One clock edge of the sequencer, written from the behavioural rules.
  function automatic ModelT modelNext(ModelT m, int dwell, StimT s);
    ModelT n = m;
    int    term;
    n.wrap = 0;
    if (s.rst) return resetModel();
    if (s.stop) begin
      n.ph = M_IDLE; n.since = 0;
      return n;
    end
    term = s.dir ? 0 : 7;
    case (m.ph)
      M_IDLE: begin
        if (s.load) n.code = s.lv;
        if (s.start) begin n.ph = M_RUN; n.since = 0; end
      end
      M_DONE: begin
        if (s.load) begin
          n.code = s.lv; n.ph = M_IDLE;
        end else if (s.start) begin
          n.code = s.dir ? 7 : 0; n.since = 0; n.ph = M_RUN;
        end
      end
      M_PAUSED: if (!s.pause) n.ph = M_RUN;
      M_RUN: begin
        if (s.pause) begin
          n.ph = M_PAUSED;
        end else begin
          n.since = m.since + 1;
          if (n.since == dwell) begin
            n.since = 0;
            if (s.cont) begin
              n.wrap = (m.code == term);
              n.code = (m.code + (s.dir ? 7 : 1)) % 8;
            end else if (m.code == term) begin
              n.ph = M_DONE;
            end else begin
              n.code = s.dir ? m.code - 1 : m.code + 1;
            end
          end
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic ExpT expOf(ModelT m);
    ExpT e;
    e.code = m.code;
    e.busy = (m.ph == M_RUN) || (m.ph == M_PAUSED);
    e.done = (m.ph == M_DONE);
    e.wrap = m.wrap;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic applyStimulus(input StimT s);
    rst      = s.rst;
    start    = s.start;
    stop     = s.stop;
    pause    = s.pause;
    dir      = s.dir;
    modeCont = s.cont;
    load     = s.load;
    loadVal  = 3'(s.lv);
    @(posedge clk);
    #1;
    m4 = modelNext(m4, 4, s);
    m1 = modelNext(m1, 1, s);
    q4.push_back(expOf(m4));
    q1.push_back(expOf(m1));
  endtask

  task automatic cyc(input bit st, input bit sp, input bit pa, input bit d,
                     input bit mc, input bit ld, input int lv, input int n = 1);
    StimT s;
    s.rst = 0; s.start = st; s.stop = sp; s.pause = pa;
    s.dir = d; s.cont = mc; s.load = ld; s.lv = lv;
    for (int i = 0; i < n; i++) applyStimulus(s);
  endtask

  task automatic holdReset(input int n);
    StimT s;
    s = '{rst: 1, start: 0, stop: 0, pause: 0, dir: 0, cont: 0, load: 0, lv: 0};
    for (int i = 0; i < n; i++) applyStimulus(s);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_code4"}, {5'd0, a4, b4, c4}, 8'd0);
    checkOutput({tag, "_busy4"}, {7'd0, busy4}, 8'd0);
    checkOutput({tag, "_done4"}, {7'd0, done4}, 8'd0);
    checkOutput({tag, "_wrap4"}, {7'd0, wrap4}, 8'd0);
    checkOutput({tag, "_code1"}, {5'd0, a1, b1, c1}, 8'd0);
    checkOutput({tag, "_busy1"}, {7'd0, busy1}, 8'd0);
    checkOutput({tag, "_done1"}, {7'd0, done1}, 8'd0);
    checkOutput({tag, "_wrap1"}, {7'd0, wrap1}, 8'd0);
  endtask

  // Reset asserted between edges; the outputs must clear before the next edge.
  task automatic asyncReset();
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async_rst");
    q4.delete();
    q1.delete();
    m4 = resetModel();
    m1 = resetModel();
  endtask

  always @(negedge clk) begin : monitor
    ExpT e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checkOutput("code_d4", {5'd0, a4, b4, c4}, 8'(e.code));
      checkOutput("busy_d4", {7'd0, busy4}, {7'd0, e.busy});
      checkOutput("done_d4", {7'd0, done4}, {7'd0, e.done});
      checkOutput("wrap_d4", {7'd0, wrap4}, {7'd0, e.wrap});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checkOutput("code_d1", {5'd0, a1, b1, c1}, 8'(e.code));
      checkOutput("busy_d1", {7'd0, busy1}, {7'd0, e.busy});
      checkOutput("done_d1", {7'd0, done1}, {7'd0, e.done});
      checkOutput("wrap_d1", {7'd0, wrap1}, {7'd0, e.wrap});
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit rDir, rCont;
    rst = 1'b1; start = 0; stop = 0; pause = 0; dir = 0; modeCont = 0; load = 0; loadVal = 0;
    m4 = resetModel();
    m1 = resetModel();
    #1;
    checkResetOutputs("por");
    holdReset(2);

    // One-shot upward sweep to DONE.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 35);

    // Load 5 with start, continuous downward scan through the 0->7 wrap.
    cyc(1, 0, 0, 1, 1, 1, 5);
    cyc(0, 0, 0, 1, 1, 0, 0, 30);
    cyc(0, 1, 0, 1, 1, 0, 0);

    // Pause in the middle of a dwell period.
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 6);
    cyc(0, 0, 1, 0, 1, 0, 0, 5);
    cyc(0, 0, 0, 0, 1, 0, 0, 10);

    // stop together with start, then a plain start resumes from the held code.
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 5);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 10);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // Finish at 7, restart downward from DONE, then load out of DONE.
    cyc(0, 0, 0, 0, 0, 1, 6);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 10);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 35);
    cyc(0, 0, 0, 1, 0, 1, 2);
    cyc(0, 0, 0, 1, 0, 0, 0, 3);

    // Randomised control traffic.
    rDir = 0;
    rCont = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) rDir = ~rDir;
      if ($urandom_range(0, 49) == 0) rCont = ~rCont;
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 9) == 0, rDir, rCont,
          $urandom_range(0, 19) == 0, int'($urandom_range(0, 7)));
    end

    // Asynchronous reset during a run.
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 4);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 9);
    asyncReset();
    holdReset(1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 6);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
